window_generator: RTL and testbench

WINDOW_GENERATOR -- requirements
Module: window_generator

---
 rtl/window_generator.sv | 174 +++++++++++++++++
 tb/tb_window_generator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_generator.sv
// Sliding K x K window generator for a raster pixel stream: K-1 line buffers feed a
// K x K shift-register window, and each completed window is registered one cycle later.
module window_generator #(
    parameter int IMG_W      = 6,
    parameter int IMG_H      = 6,
    parameter int K          = 3,
    parameter int STRIDE     = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic                           valid_out,
    output logic [K*K*DATA_WIDTH-1:0]      window_out,
    output logic                           frame_done,
    output logic [1:0]                     state_dbg
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST    = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST    = RW'(K - 1);
    localparam logic [RW-1:0] ROW_FILL_END = RW'(K - 2);
    localparam logic [PW-1:0] PH_LAST      = PW'(STRIDE - 1);

    // valid_in/valid_out handshake: there is no ready. Every cycle with valid_in=1
    // consumes data_in; valid_out=1 marks a single cycle in which window_out is new.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [PW-1:0] col_ph;
    logic [PW-1:0] row_ph;

    logic col_last;
    logic row_last;
    logic frame_end;
    logic hit;

    logic [DATA_WIDTH-1:0] line_buf [K-1][IMG_W];
    logic [DATA_WIDTH-1:0] win      [K][K];
    logic [DATA_WIDTH-1:0] win_next [K][K];
    logic [DATA_WIDTH-1:0] new_col  [K];
    logic [K*K*DATA_WIDTH-1:0] win_flat_next;

    assign col_last  = (col_cnt == COL_LAST);
    assign row_last  = (row_cnt == ROW_LAST);
    assign frame_end = valid_in && col_last && row_last;

    // Stride phases are zero exactly on the rows/columns where a window may end,
    // so no division is needed; RUN already implies row_cnt >= K-1.
    assign hit = valid_in && (state == RUN) && (col_cnt >= COL_FIRST) &&
                 (col_ph == '0) && (row_ph == '0);

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
            col_ph  <= '0;
            row_ph  <= '0;
        end else if (valid_in) begin
            if (col_last) begin
                col_cnt <= '0;
                col_ph  <= '0;
                if (row_last) begin
                    row_cnt <= '0;
                    row_ph  <= '0;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt >= ROW_FIRST) begin
                        row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
                    end
                end
            end else begin
                col_cnt <= col_cnt + 1'b1;
                if (col_cnt >= COL_FIRST) begin
                    col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (valid_in) state_next = FILL;
            FILL: if (valid_in && col_last && (row_cnt == ROW_FILL_END)) state_next = RUN;
            RUN:  if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // New window column: oldest buffered row at the top, the incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = line_buf[r][col_cnt];
        end
        new_col[K-1] = data_in;
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_next[r][c] = win[r][c+1];
            end
            win_next[r][K-1] = new_col[r];
        end
    end

    always_comb begin
        win_flat_next = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat_next[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_next[r][c];
            end
        end
    end

    // Line buffers are plain storage; stale rows are harmless because windows
    // are only emitted once K rows of the current frame have arrived.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int i = 0; i < K - 2; i++) begin
                line_buf[i][col_cnt] <= line_buf[i+1][col_cnt];
            end
            line_buf[K-2][col_cnt] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win[r][c] <= '0;
                end
            end
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            window_out <= '0;
        end else begin
            valid_out  <= hit;
            frame_done <= frame_end;
            if (valid_in) begin
                win <= win_next;
            end
            if (hit) begin
                window_out <= win_flat_next;
            end
        end
    end

endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator: a stride-1 and a stride-2 instance share one stimulus
// stream and are compared each cycle against a frame-image reference model.
module tb_window_generator;

    localparam int IMG_W = 6;
    localparam int IMG_H = 6;
    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int WW    = K * K * DW;

    logic          clk;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          valid_out  [2];
    logic [WW-1:0] window_out [2];
    logic          frame_done [2];
    logic [1:0]    state_dbg  [2];

    window_generator #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(1), .DATA_WIDTH(DW)) u_dut_s1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out[0]), .window_out(window_out[0]),
        .frame_done(frame_done[0]), .state_dbg(state_dbg[0])
    );

    window_generator #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .STRIDE(2), .DATA_WIDTH(DW)) u_dut_s2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out[1]), .window_out(window_out[1]),
        .frame_done(frame_done[1]), .state_dbg(state_dbg[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the current frame as an image plus the raster position.
    int            mrow = 0;
    int            mcol = 0;
    logic [DW-1:0] img [IMG_H][IMG_W];
    int            col_of [256];
    logic [WW-1:0] exp_q0[$];
    logic [WW-1:0] exp_q1[$];
    bit            exp_valid [2];
    logic [WW-1:0] exp_last  [2];
    bit            exp_done = 1'b0;
    int            win_seen  [2];

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nwin(input int s);
        return ((IMG_H - K) / s + 1) * ((IMG_W - K) / s + 1);
    endfunction

    function automatic int exp_state();
        if (mrow == 0 && mcol == 0) return 0;
        if (mrow < K - 1) return 1;
        return 2;
    endfunction

    function automatic logic [WW-1:0] model_window(input int r0, input int c0);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*DW +: DW] = img[r0+r][c0+c];
        return w;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input bit track);
        img[mrow][mcol] = d;
        if (track) col_of[d] = mcol;
        for (int i = 0; i < 2; i++) begin
            int s;
            s = i + 1;
            if (mrow >= K-1 && mcol >= K-1 && (mrow-(K-1)) % s == 0 && (mcol-(K-1)) % s == 0) begin
                if (i == 0) exp_q0.push_back(model_window(mrow-(K-1), mcol-(K-1)));
                else        exp_q1.push_back(model_window(mrow-(K-1), mcol-(K-1)));
                exp_valid[i] = 1'b1;
            end
        end
        exp_done = (mrow == IMG_H-1 && mcol == IMG_W-1);
        if (mcol == IMG_W-1) begin
            mcol = 0;
            mrow = (mrow == IMG_H-1) ? 0 : mrow + 1;
        end else begin
            mcol = mcol + 1;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic [WW-1:0] e;
            check($sformatf("valid_s%0d", i+1), valid_out[i], exp_valid[i]);
            if (valid_out[i] === 1'b1) win_seen[i]++;
            if (exp_valid[i]) begin
                e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("window_s%0d", i+1), window_out[i], e);
                if (col_of[e[DW-1:0]] >= 0) begin
                    for (int c = 0; c < K; c++) begin
                        for (int r = 0; r < K; r++) begin
                            logic [DW-1:0] v;
                            v = window_out[i][(r*K+c)*DW +: DW];
                            check($sformatf("wrap_col_s%0d", i+1), col_of[v], col_of[e[DW-1:0]] + c);
                        end
                    end
                end
                exp_last[i] = e;
            end else begin
                check($sformatf("hold_s%0d", i+1), window_out[i], exp_last[i]);
            end
            check($sformatf("frame_done_s%0d", i+1), frame_done[i], exp_done);
            check($sformatf("state_s%0d", i+1), state_dbg[i], exp_state());
            exp_valid[i] = 1'b0;
        end
        exp_done = 1'b0;
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit track);
        @(negedge clk);
        check_outputs();
        valid_in = v;
        data_in  = d;
        if (v) model_accept(d, track);
    endtask

    // gap_mode: 0 = continuous, 1 = idle after every pixel, 2 = random gaps of 0..3 cycles.
    // base < 0 selects random pixel data.
    task automatic send_frame(input int base, input int gap_mode, input int npix);
        if (base < 0) for (int j = 0; j < 256; j++) col_of[j] = -1;
        for (int p = 0; p < npix; p++) begin
            logic [DW-1:0] d;
            if (gap_mode == 2) repeat ($urandom_range(0, 3)) cycle(1'b0, DW'($urandom_range(0, 255)), 1'b0);
            d = (base < 0) ? DW'($urandom_range(0, 255)) : DW'(base + p);
            cycle(1'b1, d, base >= 0);
            if (gap_mode == 1) cycle(1'b0, DW'($urandom_range(0, 255)), 1'b0);
        end
    endtask

    task automatic check_count(input int nframes);
        cycle(1'b0, '0, 1'b0);
        check("count_s1", win_seen[0], nframes * nwin(1));
        check("count_s2", win_seen[1], nframes * nwin(2));
        win_seen[0] = 0;
        win_seen[1] = 0;
    endtask

    task automatic model_reset();
        mrow = 0;
        mcol = 0;
        exp_done = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        for (int i = 0; i < 2; i++) begin
            exp_valid[i] = 1'b0;
            exp_last[i]  = '0;
            win_seen[i]  = 0;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset();
        cycle(1'b0, '0, 1'b0);
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_valid_s%0d", i+1), valid_out[i], '0);
            check($sformatf("rst_window_s%0d", i+1), window_out[i], '0);
            check($sformatf("rst_done_s%0d", i+1), frame_done[i], '0);
            check($sformatf("rst_state_s%0d", i+1), state_dbg[i], '0);
        end
        model_reset();
        cycle(1'b0, '0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        for (int j = 0; j < 256; j++) col_of[j] = -1;
        model_reset();

        cycle(1'b0, '0, 1'b0);
        reset = 1'b1;
        cycle(1'b0, '0, 1'b0);

        send_frame(0, 0, IMG_W*IMG_H);
        check_count(1);

        send_frame(0, 1, IMG_W*IMG_H);
        check_count(1);

        send_frame(0, 0, IMG_W*IMG_H);
        send_frame(100, 0, IMG_W*IMG_H);
        check_count(2);

        for (int f = 0; f < 3; f++) send_frame(-1, 2, IMG_W*IMG_H);
        check_count(3);

        send_frame(0, 0, 21);
        do_reset();
        send_frame(0, 0, IMG_W*IMG_H);
        check_count(1);

        send_frame(-1, 1, IMG_W*IMG_H);
        check_count(1);

        repeat (2) cycle(1'b0, '0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
